// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and sizing constants for the counter load sequencer
package counter_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int WDOG_LIMIT = 2 ** DEF_WIDTH + 1;
endpackage

// File: rtl/counter_load_sequencer.sv
// counter_load_sequencer: drives a loadable up-counter through repeated preset-to-terminal periods
module counter_load_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] preset,
  input  logic [WIDTH-1:0] terminal,
  input  logic [REP_W-1:0] reps,
  input  logic [WIDTH-1:0] count_in,
  output logic             load,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic             err
);
  localparam logic [WIDTH:0] WDOG = (WIDTH + 1)'(2 ** WIDTH + 1);
  state_t           state;
  logic [WIDTH-1:0] preset_q, terminal_q;
  logic [REP_W-1:0] reps_q, period, period_n;
  logic [WIDTH:0]   wdog, wdog_n;
  logic             hit, last;
  // match detection, next period count and watchdog increment
  always_comb begin
    hit      = count_in == terminal_q;
    period_n = period + REP_W'(1);
    last     = (reps_q != '0) && (period_n == reps_q);
    wdog_n   = wdog + (WIDTH + 1)'(1);
  end
  // sequencer FSM with registered strobes; abort outranks start, rst outranks both
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load       <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      tc         <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      preset_q   <= '0;
      terminal_q <= '0;
      reps_q     <= '0;
      period     <= '0;
      wdog       <= '0;
    end else begin
      load <= 1'b0;
      tc   <= 1'b0;
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            preset_q   <= preset;
            terminal_q <= terminal;
            reps_q     <= reps;
            period     <= '0;
            err        <= 1'b0;
            data       <= preset;
            load       <= 1'b1;
            busy       <= 1'b1;
            state      <= LOAD;
          end
          LOAD: begin
            wdog  <= '0;
            state <= RUN;
          end
          RUN: if (hit) begin
            tc     <= 1'b1;
            period <= period_n;
            load   <= !last;
            state  <= last ? DONE : LOAD;
          end else if (wdog_n == WDOG) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wdog <= wdog_n;
          end
          default: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/counter_load_sequencer.md
Name: counter_load_sequencer

Overview:
Upstream control stage for the 4-bit loadable synchronous up-counter. Drives the counter's load/data inputs and watches its count output. Generates repeated preset-to-terminal count periods, with a terminal-count pulse per period and a done pulse after N periods. Also provides abort and a stuck-counter watchdog.

Parameters:
WIDTH, 4, width of the counter's data and count buses
REP_W, 8, width of the repeat-count input and the internal period counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a sequence; sampled only in IDLE
abort  input  1  terminate any sequence, return to IDLE
preset  input  WIDTH  reload value; latched on accepted start
terminal  input  WIDTH  terminal count; latched on accepted start
reps  input  REP_W  periods to run; 0 = run until abort
count_in  input  WIDTH  count output of the loadable counter
load  output  1  registered load strobe to the counter
data  output  WIDTH  registered load value to the counter
busy  output  1  high in every state except IDLE
tc  output  1  one-cycle pulse; count_in matched terminal
done  output  1  one-cycle pulse; reps periods completed
err  output  1  sticky watchdog error; cleared by accepted start or rst

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: load=0, data=0, busy=0, tc=0, done=0, err=0; state=IDLE; internal period and watchdog counters=0; latched preset/terminal/reps=0.
- Input priority: rst > abort > start.
- States: IDLE, LOAD, RUN, DONE. All outputs are registered.
- IDLE, start=1:
  - latch preset, terminal and reps;
  - clear period counter and err;
  - next state LOAD.
- LOAD: load=1 and data=preset_q for exactly one cycle; next state RUN. The counter takes preset at the edge ending LOAD, so count_in=preset in the first RUN cycle.
- RUN: data holds preset_q and load=0.
  - count_in==terminal_q: tc=1 next cycle; period counter increments.
  - If reps_q!=0 and the incremented count==reps_q, next state DONE; otherwise next state LOAD (reload).
- Period timing: (terminal - preset) mod 2^WIDTH + 2 cycles, from one load assertion to the next.
  - The +2 covers the registered-load cycle and the cycle in which the counter overshoots to terminal+1.
  - Wrap case (terminal < preset) uses modular arithmetic; the counter wraps 15->0.
- preset==terminal: match in the first RUN cycle; period is 2 cycles.
- DONE: done=1 for one cycle; next state IDLE.
- reps=0: never enters DONE; periods repeat until abort; the period counter wraps silently.
- Watchdog: counts RUN cycles since the last LOAD. If it reaches 2^WIDTH+1 without a match: err=1 (sticky), next state IDLE, no done.
- abort in any state: next state IDLE; load=0, tc=0 and done=0 from the next cycle; err is unchanged.
- start while busy: ignored, including in the DONE cycle.
- rst mid-sequence: all outputs and state return to reset values on that edge.
- count_in is compared only in RUN; ignored in other states.

Decomposition:
- Shared package counter_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE) with 2-bit encoding;
  - the default WIDTH=4;
  - the constant WDOG_LIMIT = 2^WIDTH+1.
- Single module, no sub-module: the FSM, period counter and watchdog are small and tightly coupled.

Test Plan:
- Reset, then start with preset=10, terminal=15, reps=1 -> load=1 with data=10 one cycle after start; tc when count_in=15; done 1 cycle after tc; busy low afterwards; load period 7.
- preset=14, terminal=1, reps=2 (wrap) -> counter runs 14,15,0,1; two tc pulses 5 cycles apart; then done; exactly 2 load pulses.
- preset=3, terminal=3, reps=3 -> tc every 2 cycles; 3 load pulses; done after the third tc.
- reps=0, preset=12, terminal=15 -> tc every 5 cycles for more than 10 periods. Abort mid-RUN -> IDLE next cycle; busy=0; no done; no further load.
- count_in held at 0 by a stub, preset=5, terminal=9 -> err=1 after 17 RUN cycles; state IDLE. A following valid start clears err.
- start pulses asserted during RUN and in the DONE cycle -> ignored; latched preset/terminal unchanged; rst during LOAD -> load=0 the next cycle.
